// File: rtl/digit_rom_arbiter_pkg.sv
// rtl/digit_rom_arbiter_pkg.sv - shared display constants and tag types for the digit ROM arbiter
package digit_rom_arbiter_pkg;

    localparam int unsigned GLYPH_PIXELS_DEF = 160;
    localparam logic [3:0]  DIGIT_MAX        = 4'd9;

    typedef enum logic {
        OWNER_SCORE = 1'b0,
        OWNER_TIME  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   blank;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // Out-of-glyph addresses and non-BCD digits read back as a blank pixel.
    function automatic logic is_blank(input logic [7:0] addr, input logic [3:0] digit,
                                      input int unsigned glyph_pixels);
        return (32'(addr) >= glyph_pixels) || (digit > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/digit_rom_arbiter_tag_delay_line.sv
// rtl/digit_rom_arbiter_tag_delay_line.sv - fixed-depth shift line carrying command tags beside the ROM
module tag_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/digit_rom_arbiter.sv
// rtl/digit_rom_arbiter.sv - round-robin sharing of one digit glyph ROM between score and time displays
module digit_rom_arbiter
    import digit_rom_arbiter_pkg::*;
#(
    parameter int          ROM_LATENCY  = 1,
    parameter int unsigned GLYPH_PIXELS = GLYPH_PIXELS_DEF
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       sync_reset,
    input  logic       req_score,
    input  logic       req_time,
    input  logic [7:0] addr_score,
    input  logic [7:0] addr_time,
    input  logic [3:0] digit_score,
    input  logic [3:0] digit_time,
    output logic       gnt_score,
    output logic       gnt_time,
    output logic       rom_en,
    output logic [7:0] rom_addr,
    output logic [3:0] rom_digit,
    input  logic       rom_pixel,
    output logic       pixel_score,
    output logic       pixel_time,
    output logic       valid_score,
    output logic       valid_time
);

    logic       favour_time;
    logic [7:0] sel_addr;
    logic [3:0] sel_digit;
    logic       sel_blank;
    tag_t       tag_in;
    tag_t       tag_out;

    always_comb begin
        gnt_score = 1'b0;
        gnt_time  = 1'b0;
        if (!sync_reset) begin
            if (req_score && (!req_time || !favour_time)) gnt_score = 1'b1;
            else if (req_time)                             gnt_time  = 1'b1;
        end
    end

    assign sel_addr     = gnt_time ? addr_time  : addr_score;
    assign sel_digit    = gnt_time ? digit_time : digit_score;
    assign sel_blank    = is_blank(sel_addr, sel_digit, GLYPH_PIXELS);
    assign tag_in.valid = gnt_score | gnt_time;
    assign tag_in.owner = gnt_time ? OWNER_TIME : OWNER_SCORE;
    assign tag_in.blank = sel_blank;

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            favour_time <= 1'b0;
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            rom_digit   <= '0;
        end else if (sync_reset) begin
            favour_time <= 1'b0;
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            rom_digit   <= '0;
        end else if (gnt_score || gnt_time) begin
            favour_time <= gnt_score;
            rom_en      <= !sel_blank;
            rom_addr    <= sel_addr;
            rom_digit   <= sel_digit;
        end else begin
            rom_en      <= 1'b0;
        end
    end

    // One extra stage beyond the ROM so the tag lines up with rom_pixel at the output register.
    tag_delay_line #(
        .DEPTH (ROM_LATENCY + 1),
        .WIDTH (TAG_W)
    ) u_tag_delay_line (
        .clock_25 (clock_25),
        .reset    (reset),
        .clear    (sync_reset),
        .din      (tag_in),
        .dout     (tag_out)
    );

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            valid_score <= 1'b0;
            valid_time  <= 1'b0;
            pixel_score <= 1'b0;
            pixel_time  <= 1'b0;
        end else if (sync_reset) begin
            valid_score <= 1'b0;
            valid_time  <= 1'b0;
            pixel_score <= 1'b0;
            pixel_time  <= 1'b0;
        end else begin
            valid_score <= tag_out.valid && (tag_out.owner == OWNER_SCORE);
            valid_time  <= tag_out.valid && (tag_out.owner == OWNER_TIME);
            if (tag_out.valid && tag_out.owner == OWNER_SCORE)
                pixel_score <= rom_pixel && !tag_out.blank;
            if (tag_out.valid && tag_out.owner == OWNER_TIME)
                pixel_time  <= rom_pixel && !tag_out.blank;
        end
    end

endmodule

// File: tb/tb_digit_rom_arbiter.sv
// tb/tb_digit_rom_arbiter.sv - directed vector bench for digit_rom_arbiter at ROM latencies 1 and 3
module tb_digit_rom_arbiter;

    logic       clock_25 = 1'b0;
    logic       reset = 1'b0;
    logic       sync_reset = 1'b0;
    logic       req_score = 1'b0, req_time = 1'b0;
    logic [7:0] addr_score = '0, addr_time = '0;
    logic [3:0] digit_score = '0, digit_time = '0;

    logic       d1_gnt_s, d1_gnt_t, d1_rom_en, d1_pix_s, d1_pix_t, d1_val_s, d1_val_t;
    logic [7:0] d1_rom_addr;
    logic [3:0] d1_rom_digit;
    logic       d3_gnt_s, d3_gnt_t, d3_rom_en, d3_pix_s, d3_pix_t, d3_val_s, d3_val_t;
    logic [7:0] d3_rom_addr;
    logic [3:0] d3_rom_digit;

    logic       rom1_q = 1'b0;
    logic [2:0] rom3_pipe = '0;

    int tests = 0;
    int fails = 0;

    always #20 clock_25 = ~clock_25;

    function automatic logic rom_f(input logic [7:0] a, input logic [3:0] d);
        return a[0] ~^ d[0];
    endfunction

    // External ROM models: registered read, 1 and 3 cycles deep.
    always @(posedge clock_25) begin
        rom1_q    <= rom_f(d1_rom_addr, d1_rom_digit);
        rom3_pipe <= {rom3_pipe[1:0], rom_f(d3_rom_addr, d3_rom_digit)};
    end

    digit_rom_arbiter #(.ROM_LATENCY(1)) dut1 (
        .clock_25 (clock_25), .reset (reset), .sync_reset (sync_reset),
        .req_score (req_score), .req_time (req_time),
        .addr_score (addr_score), .addr_time (addr_time),
        .digit_score (digit_score), .digit_time (digit_time),
        .gnt_score (d1_gnt_s), .gnt_time (d1_gnt_t),
        .rom_en (d1_rom_en), .rom_addr (d1_rom_addr), .rom_digit (d1_rom_digit),
        .rom_pixel (rom1_q),
        .pixel_score (d1_pix_s), .pixel_time (d1_pix_t),
        .valid_score (d1_val_s), .valid_time (d1_val_t)
    );

    digit_rom_arbiter #(.ROM_LATENCY(3)) dut3 (
        .clock_25 (clock_25), .reset (reset), .sync_reset (sync_reset),
        .req_score (req_score), .req_time (req_time),
        .addr_score (addr_score), .addr_time (addr_time),
        .digit_score (digit_score), .digit_time (digit_time),
        .gnt_score (d3_gnt_s), .gnt_time (d3_gnt_t),
        .rom_en (d3_rom_en), .rom_addr (d3_rom_addr), .rom_digit (d3_rom_digit),
        .rom_pixel (rom3_pipe[2]),
        .pixel_score (d3_pix_s), .pixel_time (d3_pix_t),
        .valid_score (d3_val_s), .valid_time (d3_val_t)
    );

    typedef struct {
        logic       rs;
        logic [7:0] sa;
        logic [3:0] sd;
        logic       rt;
        logic [7:0] ta;
        logic [3:0] td;
        logic       gs, gt, en, vs, ps, vt, pt;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input int rs, input int sa, input int sd, input int rt,
                                input int ta, input int td, input int gs, input int gt,
                                input int en, input int vs, input int ps, input int vt,
                                input int pt);
        vec_t v;
        v.rs = rs[0]; v.sa = sa[7:0]; v.sd = sd[3:0];
        v.rt = rt[0]; v.ta = ta[7:0]; v.td = td[3:0];
        v.gs = gs[0]; v.gt = gt[0]; v.en = en[0];
        v.vs = vs[0]; v.ps = ps[0]; v.vt = vt[0]; v.pt = pt[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic [7:0] sa, input logic [3:0] sd,
                         input logic rt, input logic [7:0] ta, input logic [3:0] td);
        req_score = rs; addr_score = sa; digit_score = sd;
        req_time  = rt; addr_time  = ta; digit_time  = td;
    endtask

    task automatic pulse_reset();
        @(negedge clock_25);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock_25);
        reset = 1'b1;
    endtask

    initial begin
        // rs sa sd | rt ta td | gs gt en | vs ps vt pt   (outputs sampled after the edge)
        vecs[0]  = mk(1,   5, 3, 0,   0,  0, 1, 0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0,   0, 0, 0,   0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0,   0, 0, 0,   0,  0, 0, 0, 0, 1, 1, 0, 0);
        vecs[3]  = mk(0,   0, 0, 1,   2,  4, 0, 1, 1, 0, 1, 0, 0);
        vecs[4]  = mk(1,   1, 1, 1,   7,  0, 1, 0, 1, 0, 1, 0, 0);
        vecs[5]  = mk(1,   1, 1, 1,   7,  0, 0, 1, 1, 0, 1, 1, 1);
        vecs[6]  = mk(1,   1, 1, 1,   7,  0, 1, 0, 1, 1, 1, 0, 1);
        vecs[7]  = mk(1,   1, 1, 1,   7,  0, 0, 1, 1, 0, 1, 1, 0);
        vecs[8]  = mk(1,   1, 1, 1,   7,  0, 1, 0, 1, 1, 1, 0, 0);
        vecs[9]  = mk(1,   1, 1, 1,   7,  0, 0, 1, 1, 0, 1, 1, 0);
        vecs[10] = mk(0,   0, 0, 0,   0,  0, 0, 0, 0, 1, 1, 0, 0);
        vecs[11] = mk(0,   0, 0, 0,   0,  0, 0, 0, 0, 0, 1, 1, 0);
        vecs[12] = mk(0,   0, 0, 1,   2,  4, 0, 1, 1, 0, 1, 0, 0);
        vecs[13] = mk(0,   0, 0, 1,   3, 11, 0, 1, 0, 0, 1, 0, 0);
        vecs[14] = mk(0,   0, 0, 1, 160,  2, 0, 1, 0, 0, 1, 1, 1);
        vecs[15] = mk(0,   0, 0, 0,   0,  0, 0, 0, 0, 0, 1, 1, 0);
        vecs[16] = mk(0,   0, 0, 0,   0,  0, 0, 0, 0, 0, 1, 1, 0);
        vecs[17] = mk(1, 159, 8, 0,   0,  0, 1, 0, 1, 0, 1, 0, 0);
        vecs[18] = mk(0,   0, 0, 0,   0,  0, 0, 0, 0, 0, 1, 0, 0);
        vecs[19] = mk(0,   0, 0, 0,   0,  0, 0, 0, 0, 1, 0, 0, 0);

        // Reset state while reset is held low.
        repeat (2) @(negedge clock_25);
        #1;
        check("reset rom_en",    d1_rom_en,    0);
        check("reset rom_addr",  d1_rom_addr,  0);
        check("reset rom_digit", d1_rom_digit, 0);
        check("reset valid",     {d1_val_s, d1_val_t}, 0);
        check("reset pixel",     {d1_pix_s, d1_pix_t}, 0);
        @(negedge clock_25);
        reset = 1'b1;

        // Table-driven main sequence on the latency-1 instance.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_25);
            drive(vecs[i].rs, vecs[i].sa, vecs[i].sd, vecs[i].rt, vecs[i].ta, vecs[i].td);
            #1;
            check($sformatf("r%0d gnt_score", i), d1_gnt_s, vecs[i].gs);
            check($sformatf("r%0d gnt_time", i),  d1_gnt_t, vecs[i].gt);
            @(posedge clock_25);
            #1;
            check($sformatf("r%0d rom_en", i),      d1_rom_en, vecs[i].en);
            check($sformatf("r%0d valid_score", i), d1_val_s,  vecs[i].vs);
            check($sformatf("r%0d pixel_score", i), d1_pix_s,  vecs[i].ps);
            check($sformatf("r%0d valid_time", i),  d1_val_t,  vecs[i].vt);
            check($sformatf("r%0d pixel_time", i),  d1_pix_t,  vecs[i].pt);
        end

        // Single score request seen by both latencies; address held while idle.
        pulse_reset();
        @(negedge clock_25);
        drive(1, 5, 3, 0, 0, 0);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clock_25);
            #1;
            check($sformatf("lat edge%0d d1 valid_score", e), d1_val_s, (e == 3) ? 1 : 0);
            check($sformatf("lat edge%0d d3 valid_score", e), d3_val_s, (e == 5) ? 1 : 0);
            if (e == 1) check("lat d3 rom_en edge1", d3_rom_en, 1);
            if (e == 2) begin
                check("lat d3 rom_en idle", d3_rom_en, 0);
                check("lat d3 rom_addr hold", d3_rom_addr, 5);
                check("lat d3 rom_digit hold", d3_rom_digit, 3);
            end
            if (e == 5) check("lat d3 pixel_score", d3_pix_s, 1);
            @(negedge clock_25);
            drive(0, 0, 0, 0, 0, 0);
        end

        // Two grants, then sync_reset squashes them and resets the pointer.
        @(negedge clock_25);
        drive(0, 0, 0, 1, 2, 4);
        #1 check("sr first gnt_time", d1_gnt_t, 1);
        @(negedge clock_25);
        drive(1, 1, 1, 0, 0, 0);
        #1 check("sr second gnt_score", d1_gnt_s, 1);
        @(negedge clock_25);
        sync_reset = 1'b1;
        drive(1, 1, 1, 1, 7, 0);
        #1 check("sr blocked grants", {d1_gnt_s, d1_gnt_t}, 0);
        @(posedge clock_25);
        #1 check("sr rom_en cleared", d1_rom_en, 0);
        check("sr valid at edge", {d1_val_s, d1_val_t}, 0);
        @(negedge clock_25);
        sync_reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock_25);
            #1;
            check($sformatf("sr squash d1 c%0d", c), {d1_val_s, d1_val_t}, 0);
            check($sformatf("sr squash d3 c%0d", c), {d3_val_s, d3_val_t}, 0);
        end
        @(negedge clock_25);
        drive(1, 1, 1, 1, 7, 0);
        #1 check("sr contention after", {d1_gnt_s, d1_gnt_t}, 2'b10);
        @(negedge clock_25);
        drive(0, 0, 0, 0, 0, 0);

        // Asynchronous reset with a full pipeline.
        @(negedge clock_25);
        drive(1, 1, 1, 1, 5, 1);
        repeat (4) @(posedge clock_25);
        #1 check("ar pixels before", {d1_pix_s, d1_pix_t}, 2'b11);
        @(negedge clock_25);
        #5 reset = 1'b0;
        #1;
        check("ar rom_en",   d1_rom_en,   0);
        check("ar rom_addr", d1_rom_addr, 0);
        check("ar rom_digit", d1_rom_digit, 0);
        check("ar d1 outs",  {d1_pix_s, d1_pix_t, d1_val_s, d1_val_t}, 0);
        check("ar d3 outs",  {d3_pix_s, d3_pix_t, d3_val_s, d3_val_t}, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock_25);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock_25);
            #1;
            check($sformatf("ar stale d1 c%0d", c), {d1_val_s, d1_val_t}, 0);
            check($sformatf("ar stale d3 c%0d", c), {d3_val_s, d3_val_t}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/digit_rom_arbiter.md
DIGIT_ROM_ARBITER -- requirements
Module: digit_rom_arbiter

Interface
REQ-001 SHALL have parameter ROM_LATENCY, default 1, meaning ROM cycles from registered address to rom_pixel (legal range 1..3).
REQ-002 SHALL have parameter GLYPH_PIXELS, default 160, meaning pixels per 10x16 digit glyph.
REQ-003 SHALL have port clock_25  in  1  pixel clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low.
REQ-005 SHALL have port sync_reset  in  1  synchronous clear, active-high.
REQ-006 SHALL have ports req_score / req_time  in  1  each requester wants one glyph pixel this cycle.
REQ-007 SHALL have ports addr_score / addr_time  in  8  glyph pixel index.
REQ-008 SHALL have ports digit_score / digit_time  in  4  BCD digit selector.
REQ-009 SHALL have ports gnt_score / gnt_time  out  1  combinational grant, same cycle as request.
REQ-010 SHALL have ports rom_en  out  1,  rom_addr  out  8,  rom_digit  out  4  registered ROM command.
REQ-011 SHALL have port rom_pixel  in  1  ROM read data.
REQ-012 SHALL have ports pixel_score / pixel_time  out  1  returned pixel, registered.
REQ-013 SHALL have ports valid_score / valid_time  out  1  one-cycle strobe qualifying the matching pixel output.

Function
REQ-014 SHALL grant at most one requester per cycle; gnt_score and gnt_time never both 1.
REQ-015 Single request SHALL be granted immediately regardless of pointer.
REQ-016 Simultaneous requests SHALL be resolved round-robin: the requester not granted last time wins; pointer updates only on a grant.
REQ-017 After reset pointer SHALL favour score (score wins first contention).
REQ-018 A denied requester SHALL hold req/addr/digit stable; max wait is 1 cycle.
REQ-019 Grant in cycle t SHALL drive rom_en=1, rom_addr, rom_digit registered at edge ending t; rom_en=0 and addr/digit hold previous values in cycles without grant.
REQ-020 A 1-bit owner tag plus valid bit SHALL travel a shift pipeline of depth ROM_LATENCY+1 alongside each command.
REQ-021 Pixel/valid for the owner SHALL be registered exactly ROM_LATENCY+1 cycles after the grant edge (total ROM_LATENCY+2 edges from request to valid); the other requester's valid stays 0.
REQ-022 Back-to-back grants SHALL be fully pipelined: one result per cycle, in grant order.
REQ-023 Request with addr >= GLYPH_PIXELS or digit > 9 SHALL be granted normally but issue rom_en=0 and return pixel 0 with valid at the normal latency.
REQ-024 pixel_* SHALL hold last value when valid_* is 0.

Reset
REQ-025 reset low SHALL asynchronously clear pointer (score favoured), all pipeline tags/valids, rom_en, rom_addr, rom_digit, pixel_*, valid_* to 0.
REQ-026 sync_reset high SHALL clear the same state at the next edge, squash all in-flight results (no valid emitted for them) and block grants that cycle.
REQ-027 Reset or sync_reset mid-pipeline SHALL produce no stale valid after release.

Structure
REQ-028 GLYPH_PIXELS, digit blank code limit (9) and owner tag encoding SHALL live in the shared display package.
REQ-029 The tag/valid delay line SHALL be a sub-module named tag_delay_line, parameterised by depth.

Verification
REQ-030 Score-only req, addr=5 digit=3, ROM returns 1 -> gnt_score same cycle, rom_addr=5 rom_digit=3 next edge, valid_score=1 pixel_score=1 at edge 3 (ROM_LATENCY=1).
REQ-031 Both request every cycle for 6 cycles -> grants alternate S,T,S,T,S,T; valids arrive in same order, one per cycle.
REQ-032 Time req digit=11 -> rom_en stays 0, valid_time=1 pixel_time=0 at normal latency; addr=160 same result.
REQ-033 sync_reset asserted one cycle after two grants -> no valid_* for either; next contention grants score.
REQ-034 reset pulsed low with pipeline full -> all outputs 0 immediately, no valid after release.
REQ-035 ROM_LATENCY=3 rerun of REQ-030 -> valid_score at edge 5.
